// File: rtl/huffman_pkg.sv
// Shared constants for the Huffman tree controller: FSM encodings, node id
// width, the root parent marker and the bit positions of the node record.
package huffman_pkg;

  localparam int ID_W = 4;

  // Parent id carried by the root record; no real node ever uses it.
  localparam logic [ID_W-1:0] ROOT_PARENT = 4'hF;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_SCAN  = 3'd2;
  localparam state_t ST_EMIT0 = 3'd3;
  localparam state_t ST_EMIT1 = 3'd4;
  localparam state_t ST_MERGE = 3'd5;
  localparam state_t ST_ROOT  = 3'd6;
  localparam state_t ST_DONE  = 3'd7;

  // Record layout {parent, side, node_id, weight}; the weight sits at bit 0.
  function automatic int rec_id_lsb(input int ws);
    return ws;
  endfunction

  function automatic int rec_side_pos(input int ws);
    return ws + ID_W;
  endfunction

  function automatic int rec_parent_lsb(input int ws);
    return ws + ID_W + 1;
  endfunction

endpackage

// File: rtl/huff_min2_tracker.sv
// Registered tracker of the two smallest active weights seen during a scan.
// Entries arrive in increasing id order and replacement needs a strictly
// smaller weight, so among equal weights the lower id is kept.
module huff_min2_tracker
  import huffman_pkg::*;
#(
  parameter int WS = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [ID_W-1:0] id,
  input  logic [WS-1:0]   weight,
  input  logic            active,
  output logic [ID_W-1:0] min1_id,
  output logic [WS-1:0]   min1_w,
  output logic [ID_W-1:0] min2_id,
  output logic [WS-1:0]   min2_w,
  output logic [ID_W-1:0] min1_id_nxt,
  output logic [WS-1:0]   min1_w_nxt
);

  logic [ID_W-1:0] m1_id_r, m2_id_r, m1_id_s, m2_id_s;
  logic [WS-1:0]   m1_w_r, m2_w_r, m1_w_s, m2_w_s;
  logic            m1_vld_r, m2_vld_r, m1_vld_s, m2_vld_s;

  // Next-state of the two minima: clear, insert as new min1, insert as min2, or hold.
  always_comb begin
    m1_id_s  = m1_id_r;
    m1_w_s   = m1_w_r;
    m1_vld_s = m1_vld_r;
    m2_id_s  = m2_id_r;
    m2_w_s   = m2_w_r;
    m2_vld_s = m2_vld_r;
    if (clr) begin
      m1_id_s  = '0;
      m1_w_s   = '0;
      m1_vld_s = 1'b0;
      m2_id_s  = '0;
      m2_w_s   = '0;
      m2_vld_s = 1'b0;
    end else if (en && active) begin
      if (!m1_vld_r || (weight < m1_w_r)) begin
        m2_id_s  = m1_id_r;
        m2_w_s   = m1_w_r;
        m2_vld_s = m1_vld_r;
        m1_id_s  = id;
        m1_w_s   = weight;
        m1_vld_s = 1'b1;
      end else if (!m2_vld_r || (weight < m2_w_r)) begin
        m2_id_s  = id;
        m2_w_s   = weight;
        m2_vld_s = 1'b1;
      end else begin
        m2_vld_s = m2_vld_r;
      end
    end else begin
      m1_vld_s = m1_vld_r;
    end
  end

  // Minimum registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_id_r  <= '0;
      m1_w_r   <= '0;
      m1_vld_r <= 1'b0;
      m2_id_r  <= '0;
      m2_w_r   <= '0;
      m2_vld_r <= 1'b0;
    end else begin
      m1_id_r  <= m1_id_s;
      m1_w_r   <= m1_w_s;
      m1_vld_r <= m1_vld_s;
      m2_id_r  <= m2_id_s;
      m2_w_r   <= m2_w_s;
      m2_vld_r <= m2_vld_s;
    end
  end

  assign min1_id     = m1_id_r;
  assign min1_w      = m1_w_r;
  assign min2_id     = m2_id_r;
  assign min2_w      = m2_w_r;
  assign min1_id_nxt = m1_id_s;
  assign min1_w_nxt  = m1_w_s;

endmodule

// File: rtl/huffman_tree_ctrl.sv
// Sequential Huffman tree builder: loads N_SYM leaf weights, then repeatedly
// scans the node table for the two lightest active nodes, emits them as the
// children of a new node, merges them, and finishes with a root record.
module huffman_tree_ctrl
  import huffman_pkg::*;
#(
  parameter int N_SYM = 4,
  parameter int W     = 4,
  parameter int WS    = W + 3
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          start,
  input  logic          sym_valid,
  output logic          sym_ready,
  input  logic [W-1:0]  sym_weight,
  output logic          rec_valid,
  input  logic          rec_ready,
  output logic [8+WS:0] rec_data,
  output logic          busy,
  output logic          done
);

  localparam int            N_NODE     = 2 * N_SYM - 1;
  localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(N_NODE - 1);
  localparam logic [ID_W-1:0] LAST_LEAF = ID_W'(N_SYM - 1);
  localparam logic [ID_W-1:0] FIRST_INT = ID_W'(N_SYM);
  localparam int            ID_LSB     = rec_id_lsb(WS);
  localparam int            SIDE_POS   = rec_side_pos(WS);
  localparam int            PAR_LSB    = rec_parent_lsb(WS);

  state_t          state_r, state_nxt;
  logic [ID_W-1:0] load_idx_r, scan_idx_r, next_id_r, active_cnt_r;
  logic [WS-1:0]   tbl_w_r   [16];
  logic            tbl_act_r [16];
  logic            sym_ready_r, rec_valid_r, busy_r, done_r;
  logic [8+WS:0]   rec_data_r, rec_data_nxt;
  logic            load_we_s, merge_we_s, trk_clr_s, trk_en_s;
  logic [WS-1:0]   sum_s, load_w_s;
  logic [ID_W-1:0] min1_id_s, min2_id_s, min1_id_nxt_s;
  logic [WS-1:0]   min1_w_s, min2_w_s, min1_w_nxt_s;

  function automatic logic [8+WS:0] pack_rec(input logic [ID_W-1:0] parent,
                                             input logic            side,
                                             input logic [ID_W-1:0] id,
                                             input logic [WS-1:0]   w);
    logic [8+WS:0] r;
    r                  = '0;
    r[PAR_LSB +: ID_W] = parent;
    r[SIDE_POS]        = side;
    r[ID_LSB +: ID_W]  = id;
    r[WS-1:0]          = w;
    return r;
  endfunction

  assign load_w_s  = {{(WS-W){1'b0}}, sym_weight};
  assign sum_s     = min1_w_s + min2_w_s;
  assign trk_clr_s = (state_r == ST_IDLE) || (state_r == ST_LOAD) || (state_r == ST_MERGE);
  assign trk_en_s  = (state_r == ST_SCAN);

  huff_min2_tracker #(.WS(WS)) u_min2 (
    .clk         (CLK),
    .rst_n       (nRST),
    .clr         (trk_clr_s),
    .en          (trk_en_s),
    .id          (scan_idx_r),
    .weight      (tbl_w_r[scan_idx_r]),
    .active      (tbl_act_r[scan_idx_r]),
    .min1_id     (min1_id_s),
    .min1_w      (min1_w_s),
    .min2_id     (min2_id_s),
    .min2_w      (min2_w_s),
    .min1_id_nxt (min1_id_nxt_s),
    .min1_w_nxt  (min1_w_nxt_s)
  );

  // Next state, table write strobes and the record to present in the next state.
  always_comb begin
    state_nxt    = state_r;
    rec_data_nxt = rec_data_r;
    load_we_s    = 1'b0;
    merge_we_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
        else       state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (sym_valid && sym_ready_r) begin
          load_we_s = 1'b1;
          if (load_idx_r == LAST_LEAF) begin
            if (N_SYM == 1) begin
              state_nxt    = ST_ROOT;
              rec_data_nxt = pack_rec(ROOT_PARENT, 1'b1, 4'd0, load_w_s);
            end else begin
              state_nxt = ST_SCAN;
            end
          end else begin
            state_nxt = ST_LOAD;
          end
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      ST_SCAN: begin
        // The last scan step updates the tracker on this same edge, so the
        // first child is taken from the tracker's next-state values.
        if (scan_idx_r == LAST_IDX) begin
          state_nxt    = ST_EMIT0;
          rec_data_nxt = pack_rec(next_id_r, 1'b0, min1_id_nxt_s, min1_w_nxt_s);
        end else begin
          state_nxt = ST_SCAN;
        end
      end
      ST_EMIT0: begin
        if (rec_ready) begin
          state_nxt    = ST_EMIT1;
          rec_data_nxt = pack_rec(next_id_r, 1'b1, min2_id_s, min2_w_s);
        end else begin
          state_nxt = ST_EMIT0;
        end
      end
      ST_EMIT1: begin
        if (rec_ready) begin
          state_nxt    = ST_MERGE;
          rec_data_nxt = '0;
        end else begin
          state_nxt = ST_EMIT1;
        end
      end
      ST_MERGE: begin
        merge_we_s = 1'b1;
        // The node created here is the last one when only two were active.
        if (active_cnt_r == 4'd2) begin
          state_nxt    = ST_ROOT;
          rec_data_nxt = pack_rec(ROOT_PARENT, 1'b1, next_id_r, sum_s);
        end else begin
          state_nxt = ST_SCAN;
        end
      end
      ST_ROOT: begin
        if (rec_ready) begin
          state_nxt    = ST_DONE;
          rec_data_nxt = '0;
        end else begin
          state_nxt = ST_ROOT;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt    = ST_IDLE;
        rec_data_nxt = '0;
      end
    endcase
  end

  // FSM state, counters and registered outputs derived from the next state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r      <= ST_IDLE;
      load_idx_r   <= '0;
      scan_idx_r   <= '0;
      next_id_r    <= '0;
      active_cnt_r <= '0;
      sym_ready_r  <= 1'b0;
      rec_valid_r  <= 1'b0;
      rec_data_r   <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      rec_data_r  <= rec_data_nxt;
      sym_ready_r <= (state_nxt == ST_LOAD);
      rec_valid_r <= (state_nxt == ST_EMIT0) || (state_nxt == ST_EMIT1) || (state_nxt == ST_ROOT);
      busy_r      <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      done_r      <= (state_nxt == ST_DONE);
      scan_idx_r  <= ((state_r == ST_SCAN) && (state_nxt == ST_SCAN)) ? scan_idx_r + 4'd1 : 4'd0;
      if ((state_r == ST_IDLE) && start) begin
        load_idx_r   <= '0;
        next_id_r    <= FIRST_INT;
        active_cnt_r <= ID_W'(N_SYM);
      end else if (load_we_s) begin
        load_idx_r <= load_idx_r + 4'd1;
      end else if (merge_we_s) begin
        next_id_r    <= next_id_r + 4'd1;
        active_cnt_r <= active_cnt_r - 4'd1;
      end else begin
        load_idx_r <= load_idx_r;
      end
    end
  end

  // Node table: cleared on reset and at each new build, written by load and merge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 16; i++) begin
        tbl_w_r[i]   <= '0;
        tbl_act_r[i] <= 1'b0;
      end
    end else if ((state_r == ST_IDLE) && start) begin
      for (int i = 0; i < 16; i++) begin
        tbl_w_r[i]   <= '0;
        tbl_act_r[i] <= 1'b0;
      end
    end else if (load_we_s) begin
      tbl_w_r[load_idx_r]   <= load_w_s;
      tbl_act_r[load_idx_r] <= 1'b1;
    end else if (merge_we_s) begin
      tbl_act_r[min1_id_s] <= 1'b0;
      tbl_act_r[min2_id_s] <= 1'b0;
      tbl_w_r[next_id_r]   <= sum_s;
      tbl_act_r[next_id_r] <= 1'b1;
    end else begin
      tbl_act_r[0] <= tbl_act_r[0];
    end
  end

  assign sym_ready = sym_ready_r;
  assign rec_valid = rec_valid_r;
  assign rec_data  = rec_data_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_huffman_tree_ctrl.sv
// Directed bench for huffman_tree_ctrl with N_SYM=4, W=4 (16-bit records).
module tb_huffman_tree_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start;
  logic        sym_valid;
  logic        sym_ready;
  logic [3:0]  sym_weight;
  logic        rec_valid;
  logic        rec_ready;
  logic [15:0] rec_data;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic [15:0] rx [16];
  int rx_n;

  typedef struct {
    string        name;
    logic [15:0]  w;      // {w3,w2,w1,w0}
    int           stall;
    logic [111:0] exp;    // record i at [16*i +: 16]
  } vec_t;

  vec_t vecs [5];

  huffman_tree_ctrl #(.N_SYM(4), .W(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .start      (start),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_weight (sym_weight),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_data   (rec_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  function automatic logic [15:0] rec(input int p, input int s, input int i, input int w);
    logic [3:0] pp;
    logic       ss;
    logic [3:0] ii;
    logic [6:0] ww;
    pp = p[3:0];
    ss = s[0];
    ii = i[3:0];
    ww = w[6:0];
    return {pp, ss, ii, ww};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Start a build, load weights, collect records until done (or abort by reset).
  task automatic run_build(input logic [15:0] w, input int stall, input int abort_at, input bit poke);
    int wait_cnt;
    logic [15:0] held;
    bit got_done;
    rx_n = 0;
    for (int i = 0; i < 16; i++) rx[i] = '0;
    @(posedge CLK);
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("sym_ready_in_load", {31'd0, sym_ready}, 32'd1);
      sym_valid  = 1'b1;
      sym_weight = w[4*i +: 4];
      @(negedge CLK);
    end
    sym_valid  = 1'b0;
    sym_weight = 4'd0;
    rec_ready  = (stall == 0);
    got_done   = 1'b0;
    wait_cnt   = 0;
    held       = '0;
    for (int cyc = 0; cyc < 600 && !got_done; cyc++) begin
      if (done) begin
        got_done = 1'b1;
      end else if (rec_valid) begin
        if (abort_at >= 0 && rx_n == abort_at) begin
          nRST = 1'b0;
          return;
        end
        if (wait_cnt > 0) check("rec_data_stable", {16'd0, rec_data}, {16'd0, held});
        held = rec_data;
        if (wait_cnt < stall) begin
          rec_ready = 1'b0;
          wait_cnt++;
        end else begin
          rec_ready = 1'b1;
          if (rx_n < 16) rx[rx_n] = rec_data;
          rx_n++;
          wait_cnt = 0;
        end
      end else begin
        rec_ready = (stall == 0);
      end
      if (poke && cyc == 3) begin
        start      = 1'b1;
        sym_valid  = 1'b1;
        sym_weight = 4'hF;
      end else if (poke && cyc == 4) begin
        start      = 1'b0;
        sym_valid  = 1'b0;
        sym_weight = 4'd0;
      end
      @(negedge CLK);
    end
    rec_ready = 1'b1;
    if (!got_done) check("build_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_recs(input string tag, input logic [111:0] exp);
    check({tag, "_rec_count"}, rx_n, 32'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("%s_rec%0d", tag, i), {16'd0, rx[i]}, {16'd0, exp[16*i +: 16]});
  endtask

  task automatic check_tail(input string tag, input bit want_latency);
    repeat (3) @(negedge CLK);
    check({tag, "_done_once"}, done_cnt, 32'd1);
    check({tag, "_idle_after"}, {30'd0, busy, rec_valid}, 32'd0);
    if (want_latency) check({tag, "_busy_cycles"}, busy_cnt, 32'd35);
  endtask

  initial begin
    logic [111:0] exp_f;
    nRST       = 1'b0;
    start      = 1'b0;
    sym_valid  = 1'b0;
    sym_weight = 4'd0;
    rec_ready  = 1'b1;

    vecs[0] = '{"w3125", {4'd5, 4'd2, 4'd1, 4'd3}, 0,
               {rec(15,1,6,11), rec(6,1,5,6), rec(6,0,3,5), rec(5,1,4,3),
                rec(5,0,0,3), rec(4,1,2,2), rec(4,0,1,1)}};
    vecs[1] = '{"w3125_stall", {4'd5, 4'd2, 4'd1, 4'd3}, 3,
               {rec(15,1,6,11), rec(6,1,5,6), rec(6,0,3,5), rec(5,1,4,3),
                rec(5,0,0,3), rec(4,1,2,2), rec(4,0,1,1)}};
    vecs[2] = '{"ties", {4'd2, 4'd2, 4'd2, 4'd2}, 0,
               {rec(15,1,6,8), rec(6,1,5,4), rec(6,0,4,4), rec(5,1,3,2),
                rec(5,0,2,2), rec(4,1,1,2), rec(4,0,0,2)}};
    vecs[3] = '{"zeros", {4'd0, 4'd0, 4'd0, 4'd0}, 0,
               {rec(15,1,6,0), rec(6,1,5,0), rec(6,0,4,0), rec(5,1,3,0),
                rec(5,0,2,0), rec(4,1,1,0), rec(4,0,0,0)}};
    vecs[4] = '{"w4321", {4'd1, 4'd2, 4'd3, 4'd4}, 0,
               {rec(15,1,6,10), rec(6,1,5,6), rec(6,0,0,4), rec(5,1,4,3),
                rec(5,0,1,3), rec(4,1,2,2), rec(4,0,3,1)}};
    exp_f = {rec(15,1,6,60), rec(6,1,5,30), rec(6,0,4,30), rec(5,1,3,15),
             rec(5,0,2,15), rec(4,1,1,15), rec(4,0,0,15)};

    // Reset state.
    repeat (3) @(negedge CLK);
    check("reset_outputs", {11'd0, sym_ready, rec_valid, busy, done, rec_data}, 32'd0);
    nRST = 1'b1;

    // sym_valid in IDLE is ignored.
    for (int i = 0; i < 3; i++) begin
      sym_valid  = 1'b1;
      sym_weight = 4'd9;
      @(negedge CLK);
      check("idle_sym_ready_low", {30'd0, sym_ready, busy}, 32'd0);
    end
    sym_valid  = 1'b0;
    sym_weight = 4'd0;

    // Table-driven builds.
    for (int v = 0; v < 5; v++) begin
      run_build(vecs[v].w, vecs[v].stall, -1, 1'b0);
      check_recs(vecs[v].name, vecs[v].exp);
      check_tail(vecs[v].name, vecs[v].stall == 0);
    end

    // start and sym_valid poked while busy: same record sequence.
    run_build(vecs[0].w, 0, -1, 1'b1);
    check_recs("poke", vecs[0].exp);
    check_tail("poke", 1'b0);

    // Reset during round-2 EMIT0, then a fresh build of all-15 weights.
    run_build(vecs[0].w, 0, 2, 1'b0);
    check("abort_rec_count", rx_n, 32'd2);
    @(negedge CLK);
    check("abort_reset_outputs", {11'd0, sym_ready, rec_valid, busy, done, rec_data}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("no_stale_after_reset", {30'd0, rec_valid, busy}, 32'd0);
    end
    run_build({4'd15, 4'd15, 4'd15, 4'd15}, 0, -1, 1'b0);
    check_recs("w15", exp_f);
    check_tail("w15", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
